// File: rtl/mem_stage.sv
// MEM pipeline stage: request/ack data-memory access, BEQ resolution, registered MEM/WB outputs.
// Optional MEM_TIMEOUT_EN aborts a memory access that is not acknowledged within TIMEOUT_CYCLES.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        VALID_IN,
    input  logic        ZERO_IN,
    input  logic [31:0] BRANCH_IN,
    input  logic [31:0] ALU_VAL_IN,
    input  logic [31:0] RT_READ_IN,
    input  logic [4:0]  REG_DESTINATION_IN,
    input  logic [5:0]  ALU_CONTROL_IN,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        STALL,
    output logic        PC_SRC,
    output logic [31:0] BRANCH_TARGET,
    output logic        WB_WRITE,
    output logic [4:0]  WB_DEST,
    output logic [31:0] WB_DATA,
    output logic        MISALIGN,
    output logic        MEM_ERR
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam logic [5:0]  OP_LW  = 6'h23;
    localparam logic [5:0]  OP_SW  = 6'h2B;
    localparam logic [5:0]  OP_BEQ = 6'h04;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [REG_W-1:0]    dest_q, dest_d;
    logic                pc_src_q, pc_src_d;
    logic [DATA_W-1:0]   branch_target_q, branch_target_d;
    logic                wb_write_q, wb_write_d;
    logic [REG_W-1:0]    wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                misalign_q, misalign_d;
    logic                stall;
    logic                is_mem;
    logic                aligned;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic                timeout;
`endif

    assign is_mem  = VALID_IN & ((ALU_CONTROL_IN == OP_LW) | (ALU_CONTROL_IN == OP_SW));
    assign aligned = (ALU_VAL_IN[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    // Limit reached in the WAIT cycle whose count equals TIMEOUT_CYCLES-1; ACK still wins.
    assign timeout = (state_q == S_WAIT) & ~MEM_ACK
                   & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, stall and registered-output logic
    always_comb begin
        state_d         = state_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        dest_d          = dest_q;
        branch_target_d = branch_target_q;
        wb_dest_d       = wb_dest_q;
        wb_data_d       = wb_data_q;
        pc_src_d        = 1'b0;
        wb_write_d      = 1'b0;
        misalign_d      = 1'b0;
        stall           = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d      = wait_cnt_q;
        mem_err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    if (aligned) begin
                        stall       = 1'b1;
                        state_d     = S_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ALU_CONTROL_IN == OP_SW);
                        mem_addr_d  = ALU_VAL_IN;
                        mem_wdata_d = RT_READ_IN;
                        dest_d      = REG_DESTINATION_IN;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_d  = '0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else if (VALID_IN) begin
                    if (ALU_CONTROL_IN == OP_BEQ) begin
                        pc_src_d        = ZERO_IN;
                        branch_target_d = BRANCH_IN;
                    end else begin
                        wb_data_d  = ALU_VAL_IN;
                        wb_dest_d  = REG_DESTINATION_IN;
                        wb_write_d = (REG_DESTINATION_IN != '0);
                    end
                end
            end
            S_WAIT: begin
                if (MEM_ACK) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        wb_data_d  = MEM_RDATA;
                        wb_dest_d  = dest_q;
                        wb_write_d = (dest_q != '0);
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
`endif
                end else begin
                    stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= S_IDLE;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            dest_q          <= '0;
            pc_src_q        <= 1'b0;
            branch_target_q <= '0;
            wb_write_q      <= 1'b0;
            wb_dest_q       <= '0;
            wb_data_q       <= '0;
            misalign_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q      <= '0;
            mem_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            dest_q          <= dest_d;
            pc_src_q        <= pc_src_d;
            branch_target_q <= branch_target_d;
            wb_write_q      <= wb_write_d;
            wb_dest_q       <= wb_dest_d;
            wb_data_q       <= wb_data_d;
            misalign_q      <= misalign_d;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
            mem_err_q       <= mem_err_d;
`endif
        end
    end

    assign MEM_REQ       = mem_req_q;
    assign MEM_WE        = mem_we_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_WDATA     = mem_wdata_q;
    assign STALL         = stall;
    assign PC_SRC        = pc_src_q;
    assign BRANCH_TARGET = branch_target_q;
    assign WB_WRITE      = wb_write_q;
    assign WB_DEST       = wb_dest_q;
    assign WB_DATA       = wb_data_q;
    assign MISALIGN      = misalign_q;
`ifdef MEM_TIMEOUT_EN
    assign MEM_ERR       = mem_err_q;
`else
    assign MEM_ERR       = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs: ALU result, store data, destination, control, zero flag and branch target.
- Drives a request/acknowledge data-memory bus for loads and stores, and resolves BEQ.
- Produces registered MEM/WB writeback outputs.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: max WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- VALID_IN  in  1  EX/MEM slot holds a live instruction
- ZERO_IN  in  1  ALU zero flag from EX/MEM
- BRANCH_IN  in  32  branch target from EX/MEM
- ALU_VAL_IN  in  32  ALU result / memory address
- RT_READ_IN  in  32  store data
- REG_DESTINATION_IN  in  5  writeback register index
- ALU_CONTROL_IN  in  6  opcode: 6'h23 LW, 6'h2B SW, 6'h04 BEQ, any other value is register-writeback ALU op
- MEM_REQ  out  1  memory request, registered
- MEM_WE  out  1  1 = store, 0 = load; valid while MEM_REQ
- MEM_ADDR  out  32  word address, latched
- MEM_WDATA  out  32  store data, latched
- MEM_RDATA  in  32  load data, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion strobe
- STALL  out  1  combinational; hold EX/MEM and earlier stages
- PC_SRC  out  1  registered; branch taken
- BRANCH_TARGET  out  32  registered target, valid with PC_SRC
- WB_WRITE  out  1  registered; write WB_DATA to WB_DEST
- WB_DEST  out  5  registered destination
- WB_DATA  out  32  registered writeback data
- MISALIGN  out  1  registered one-cycle pulse on misaligned LW/SW
- MEM_ERR  out  1  registered one-cycle pulse on timeout (0 when feature disabled)

Behaviour:
- Reset values:
  - All registered outputs 0.
  - FSM in IDLE; MEM_REQ drops immediately on RESET, including mid-access.
  - Pending access discarded; no writeback.
- Definitions:
  - is_mem = VALID_IN & (op==LW | op==SW).
  - aligned = ALU_VAL_IN[1:0]==0.
- FSM states are IDLE and WAIT.
- IDLE, is_mem & aligned:
  - STALL=1.
  - At the next edge: MEM_REQ<=1, MEM_WE<=(op==SW), MEM_ADDR<=ALU_VAL_IN, MEM_WDATA<=RT_READ_IN, dest and op latched, WB_WRITE<=0, go to WAIT.
- IDLE, is_mem & !aligned: STALL=0, no request, MISALIGN<=1 for one cycle, WB_WRITE<=0.
- IDLE, other valid op: single-cycle pass-through, no stall.
  - ALU op: WB_DATA<=ALU_VAL_IN, WB_DEST<=REG_DESTINATION_IN, WB_WRITE<=(dest!=0).
  - BEQ: WB_WRITE<=0; PC_SRC<=ZERO_IN, BRANCH_TARGET<=BRANCH_IN.
  - Any op other than BEQ drives PC_SRC<=0.
- IDLE, VALID_IN=0: WB_WRITE<=0, PC_SRC<=0.
- WAIT, MEM_ACK=0:
  - STALL=1; MEM_REQ, MEM_ADDR, MEM_WE and MEM_WDATA held stable.
  - WB_WRITE<=0 each cycle (bubble).
- WAIT, MEM_ACK=1:
  - STALL=0, so upstream advances at this edge.
  - At the edge: MEM_REQ<=0, go to IDLE.
  - LW: WB_DATA<=MEM_RDATA, WB_DEST<=latched dest, WB_WRITE<=(dest!=0).
  - SW: WB_WRITE<=0.
- Latency:
  - ALU op/BEQ: result 1 cycle after presentation.
  - LW/SW with ACK in the first WAIT cycle: 2 cycles, 1 stall cycle.
  - Each extra wait cycle adds 1.
- MEM_ACK in IDLE is ignored. MEM_RDATA is sampled only in the ACK cycle.
- Back-to-back memory ops: the second op is presented in the cycle after ACK and re-enters WAIT via one IDLE cycle. No request is ever merged.
- MISALIGN, MEM_ERR and PC_SRC are single-cycle pulses.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle without ACK.
  - When it reaches TIMEOUT_CYCLES with no ACK that cycle: STALL=0 that cycle.
  - At the edge: MEM_REQ<=0, MEM_ERR<=1 for one cycle, WB_WRITE<=0, go to IDLE.
  - ACK arriving in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; WAIT persists until ACK or RESET; MEM_ERR tied 0.

Test Plan:
1. ALU op: ALU_CONTROL_IN=6'h00, ALU_VAL_IN=32'h1234, dest=5 -> next cycle WB_WRITE=1, WB_DEST=5, WB_DATA=32'h1234, STALL never high.
2. LW, ACK after 3 WAIT cycles:
   - Stimulus: addr 32'h40, dest 8, MEM_RDATA=32'hDEADBEEF in ACK cycle.
   - Response: MEM_REQ=1, MEM_WE=0, MEM_ADDR=32'h40 held 3 cycles; STALL high 3 cycles, low in ACK cycle; then WB_DATA=32'hDEADBEEF, WB_DEST=8, WB_WRITE=1.
3. SW with ACK in the first WAIT cycle:
   - Stimulus: addr 32'h44, RT_READ_IN=32'hA5A5A5A5.
   - Response: MEM_WE=1, MEM_WDATA=32'hA5A5A5A5; exactly 1 stall cycle; WB_WRITE stays 0.
4. LW at addr 32'h42 -> MISALIGN pulses once, MEM_REQ stays 0, WB_WRITE=0, no stall.
5. BEQ, ZERO_IN=1, BRANCH_IN=32'h100 -> next cycle PC_SRC=1, BRANCH_TARGET=32'h100 for one cycle. With ZERO_IN=0 -> PC_SRC=0.
6. RESET asserted during WAIT -> MEM_REQ falls immediately (before the next edge), state IDLE, no writeback. Sub-case, MEM_TIMEOUT_EN defined with TIMEOUT_CYCLES=4 and ACK withheld -> MEM_ERR pulses at cycle 4, then MEM_REQ=0.
